// File: rtl/sdram_stream_writer_if.sv
// rtl/sdram_stream_writer_if.sv - sdram_bus request/ack channel between an initiator and the SDRAM controller
//
// Signals:
//   req        one-cycle request pulse (controller latches it)
//   ack        one-cycle completion pulse from the controller
//   address    word address
//   data_write write data, [7:0] even byte lane, [15:8] odd byte lane
//   data_read  read data (unused by write-only initiators)
//   we         write enable
//   wm         byte write mask, 1 = lane not written; wm[0] even lane, wm[1] odd lane
// Modports:
//   master / controller  initiator side (drives req/address/data_write/we/wm)
//   slave                memory-controller side
interface sdram_bus #(
  parameter int ADDR_BITS = 22
);
  logic                 req;
  logic                 ack;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          data_write;
  logic [15:0]          data_read;
  logic                 we;
  logic [1:0]           wm;

  modport master (
    output req, address, data_write, we, wm,
    input  ack, data_read
  );

  modport controller (
    output req, address, data_write, we, wm,
    input  ack, data_read
  );

  modport slave (
    input  req, address, data_write, we, wm,
    output ack, data_read
  );
endinterface

// File: rtl/sdram_stream_writer.sv
// rtl/sdram_stream_writer.sv - packs a byte stream into masked 16-bit SDRAM word writes
//
// Ports:
//   i_clk         system clock (shared with the SDRAM controller)
//   i_reset       asynchronous active-high reset
//   i_start       pulse: begin a stream at i_base_addr (ignored while busy)
//   i_base_addr   byte address of first byte; LSB picks the byte lane
//   i_byte_valid  stream byte valid
//   i_byte_data   stream byte
//   o_byte_ready  byte taken when i_byte_valid && o_byte_ready
//   i_flush       pulse: write any partial word, then finish once all writes are acked
//   o_busy        high from accepted start through the done cycle
//   o_done        one-cycle pulse when the flushed stream is fully written
//   mem           sdram_bus initiator port
module sdram_stream_writer #(
  parameter int ADDR_BITS  = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_BITS:0] i_base_addr,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte_data,
  output logic               o_byte_ready,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_done,
  sdram_bus.master           mem
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]        PTR_ONE  = (PW+1)'(1);
  localparam logic [PW:0]        DEPTH_L  = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] BPTR_ONE = (ADDR_BITS+1)'(1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [0:0] I_IDLE = 1'b0;
  localparam logic [0:0] I_WAIT = 1'b1;

  logic [1:0]           r_state;
  logic [0:0]           r_istate;
  logic [ADDR_BITS:0]   r_bptr;
  logic [7:0]           r_lo;
  logic                 r_lo_valid;

  logic [ADDR_BITS-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [15:0]          r_fifo_data [FIFO_DEPTH];
  logic [1:0]           r_fifo_wm   [FIFO_DEPTH];
  logic [PW:0]          r_wr_ptr;
  logic [PW:0]          r_rd_ptr;

  logic                 r_req;
  logic                 r_we;
  logic [1:0]           r_wm;
  logic [ADDR_BITS-1:0] r_addr;
  logic [15:0]          r_wdata;

  logic [PW:0]          w_count;
  logic                 w_empty;
  logic                 w_full;
  logic [PW-1:0]        w_head_idx;
  logic [PW-1:0]        w_next_idx;
  logic                 w_accept;
  logic                 w_push_odd;
  logic                 w_push_flush;
  logic                 w_push;
  logic [15:0]          w_push_data;
  logic [1:0]           w_push_wm;
  logic                 w_ack_pop;
  logic                 w_drained;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == DEPTH_L);
  assign w_head_idx = r_rd_ptr[PW-1:0];
  assign w_next_idx = w_head_idx + PW'(1);

  assign o_byte_ready = (r_state == S_RUN) && !i_flush && !w_full;
  assign o_busy       = (r_state != S_OFF);
  assign o_done       = (r_state == S_DONE);

  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_push_odd   = w_accept && r_bptr[0];
  // The trailing even byte may have to wait for a free slot if the FIFO filled just before flush.
  assign w_push_flush = (r_state == S_FLUSH) && r_lo_valid && !w_full;
  assign w_push       = w_push_odd || w_push_flush;
  assign w_push_data  = w_push_odd ? {i_byte_data, r_lo} : {8'h00, r_lo};
  assign w_push_wm    = w_push_odd ? (r_lo_valid ? 2'b00 : 2'b01) : 2'b10;

  assign w_ack_pop = (r_istate == I_WAIT) && mem.ack;
  // Drained either already, or by the ack of the very last entry this cycle.
  assign w_drained = (w_empty && (r_istate == I_IDLE)) || (w_ack_pop && (w_count == PTR_ONE));

  assign mem.req        = r_req;
  assign mem.we         = r_we;
  assign mem.wm         = r_wm;
  assign mem.address    = r_addr;
  assign mem.data_write = r_wdata;

  // Stream FSM and byte packer
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_OFF;
      r_bptr     <= '0;
      r_lo       <= '0;
      r_lo_valid <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_bptr     <= i_base_addr;
            r_lo       <= '0;
            r_lo_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_state <= S_FLUSH;
          end else if (w_accept) begin
            r_bptr <= r_bptr + BPTR_ONE;
            if (!r_bptr[0]) begin
              r_lo       <= i_byte_data;
              r_lo_valid <= 1'b1;
            end else begin
              r_lo       <= '0;
              r_lo_valid <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (w_push_flush) begin
            r_lo       <= '0;
            r_lo_valid <= 1'b0;
          end else if (!r_lo_valid && w_drained) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  // Word FIFO write side
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_addr[i] <= '0;
        r_fifo_data[i] <= '0;
        r_fifo_wm[i]   <= 2'b11;
      end
    end else if (w_push) begin
      r_fifo_addr[r_wr_ptr[PW-1:0]] <= r_bptr[ADDR_BITS:1];
      r_fifo_data[r_wr_ptr[PW-1:0]] <= w_push_data;
      r_fifo_wm[r_wr_ptr[PW-1:0]]   <= w_push_wm;
      r_wr_ptr                      <= r_wr_ptr + PTR_ONE;
    end
  end

  // Issuer: one outstanding transaction, req is a single-cycle pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_istate <= I_IDLE;
      r_rd_ptr <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_wm     <= 2'b11;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_istate)
        I_IDLE: begin
          if (!w_empty) begin
            r_addr   <= r_fifo_addr[w_head_idx];
            r_wdata  <= r_fifo_data[w_head_idx];
            r_wm     <= r_fifo_wm[w_head_idx];
            r_we     <= 1'b1;
            r_req    <= 1'b1;
            r_istate <= I_WAIT;
          end
        end
        default: begin
          r_req <= 1'b0;
          if (mem.ack) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            // Back-to-back: issue the next entry in the cycle right after the ack.
            if (w_count > PTR_ONE) begin
              r_addr  <= r_fifo_addr[w_next_idx];
              r_wdata <= r_fifo_data[w_next_idx];
              r_wm    <= r_fifo_wm[w_next_idx];
              r_req   <= 1'b1;
            end else begin
              r_we     <= 1'b0;
              r_istate <= I_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// tb/tb_sdram_stream_writer.sv - randomized self-checking bench for sdram_stream_writer
module tb_sdram_stream_writer;
  localparam int AB = 22;
  localparam int FD = 4;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    wm;
    logic          we;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB:0]   base_addr;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          flush;
  logic          busy;
  logic          done;

  sdram_bus #(.ADDR_BITS(AB)) bus ();
  assign bus.data_read = '0;

  sdram_stream_writer #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_ready (byte_ready),
    .i_flush      (flush),
    .o_busy       (busy),
    .o_done       (done),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  wr_t writes[$];
  int  wcyc[$];
  wr_t exp[$];
  logic [7:0] stim[$];
  int ack_delay = 2;
  int cnt_down = 0;
  int acks = 0;
  int last_ack_cyc = 0;
  int req_viol = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc1 = 0;
  int acc_before_ack = 0;
  bit outstanding = 1'b0;
  bit prev_req = 1'b0;

  // SDRAM controller model: records each req, acks after ack_delay cycles, flags held or overlapping reqs.
  always @(negedge clk) begin
    cyc++;
    bus.ack = 1'b0;
    if (bus.req === 1'b1) begin
      if (prev_req || outstanding) req_viol++;
      writes.push_back('{bus.address, bus.data_write, bus.wm, bus.we});
      wcyc.push_back(cyc);
      outstanding = 1'b1;
      cnt_down = ack_delay;
    end
    prev_req = (bus.req === 1'b1);
    if (outstanding) begin
      if (cnt_down == 0) begin
        bus.ack = 1'b1;
        outstanding = 1'b0;
        acks++;
        last_ack_cyc = cyc;
      end else begin
        cnt_down--;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Expected writes: each byte lands at (base + i) mod 2^(AB+1); bytes sharing a word address merge.
  task automatic build_model(input logic [AB:0] base);
    logic [AB:0]   a;
    logic [AB-1:0] w;
    logic [15:0]   d;
    logic [1:0]    m;
    bit            have;
    exp.delete();
    have = 1'b0;
    w = '0;
    d = '0;
    m = 2'b11;
    foreach (stim[i]) begin
      a = base + (AB+1)'(i);
      if (have && a[AB:1] != w) begin
        exp.push_back('{w, d, m, 1'b1});
        have = 1'b0;
      end
      if (!have) begin
        w = a[AB:1];
        d = 16'h0000;
        m = 2'b11;
        have = 1'b1;
      end
      if (a[0]) begin
        d[15:8] = stim[i];
        m[1] = 1'b0;
      end else begin
        d[7:0] = stim[i];
        m[0] = 1'b0;
      end
    end
    if (have) exp.push_back('{w, d, m, 1'b1});
  endtask

  task automatic prep();
    writes.delete();
    wcyc.delete();
    req_viol = 0;
    acks = 0;
    acc_before_ack = 0;
  endtask

  task automatic drive_stream(input logic [AB:0] base, input int restart_at, input bit flush_with_start);
    int idx;
    int guard;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    flush = flush_with_start;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < stim.size() && guard < 4000) begin
      byte_valid = 1'b1;
      byte_data = stim[idx];
      start = (idx == restart_at);
      base_addr = (idx == restart_at) ? ~base : base;
      #1;
      if (byte_ready) begin
        if (idx == 1) acc_cyc1 = cyc;
        if (acks == 0) acc_before_ack++;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    base_addr = base;
    if (guard >= 4000) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout accepted %0d bytes, required %0d", idx, stim.size());
    end
  endtask

  task automatic finish_stream(output int d0);
    int guard;
    d0 = done_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      tests++;
      fails++;
      $display("FAIL done_timeout no done pulse within 3000 cycles");
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, byte_ready, bus.req, bus.we} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got busy/done/ready/req/we=%b required 00000", {busy, done, byte_ready, bus.req, bus.we});
    end
    tests++;
    if ({bus.wm, bus.address, bus.data_write} !== {2'b11, {AB{1'b0}}, 16'h0}) begin
      fails++;
      $display("FAIL reset_bus got wm=%b addr=%h data=%h required wm=11 addr=0 data=0", bus.wm, bus.address, bus.data_write);
    end
  endtask

  task automatic test_basic();
    int d0;
    prep();
    ack_delay = 3;
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp = '{'{22'h000008, 16'hBBAA, 2'b00, 1'b1}, '{22'h000009, 16'hDDCC, 2'b00, 1'b1}};
    drive_stream(23'h000010, -1, 1'b0);
    finish_stream(d0);
    tests++;
    if (writes.size() != exp.size()) begin
      fails++;
      $display("FAIL basic_count got %0d writes required %0d", writes.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < writes.size(); i++) begin
      tests++;
      if (writes[i] !== exp[i]) begin
        fails++;
        $display("FAIL basic_write%0d got a=%h d=%h wm=%b we=%b required a=%h d=%h wm=%b we=%b", i,
                 writes[i].addr, writes[i].data, writes[i].wm, writes[i].we, exp[i].addr, exp[i].data, exp[i].wm, exp[i].we);
      end
    end
    tests++;
    if (wcyc.size() > 0 && wcyc[0] != acc_cyc1 + 2) begin
      fails++;
      $display("FAIL basic_req_latency got %0d cycles required 2", wcyc[0] - acc_cyc1);
    end
    tests++;
    if (done_cyc - last_ack_cyc != 1) begin
      fails++;
      $display("FAIL basic_done_latency got %0d cycles required 1", done_cyc - last_ack_cyc);
    end
    tests++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_busy got pulses=%0d busy=%b required pulses=1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_packing();
    logic [AB:0] base;
    int d0;
    for (int c = 0; c < 3; c++) begin
      prep();
      ack_delay = 1 + c;
      case (c)
        0: begin
          base = 23'h000011;
          stim = '{8'h11, 8'h22, 8'h33};
          exp = '{'{22'h000008, 16'h1100, 2'b01, 1'b1}, '{22'h000009, 16'h3322, 2'b00, 1'b1}};
        end
        1: begin
          base = 23'h000000;
          stim = '{8'h5A};
          exp = '{'{22'h000000, 16'h005A, 2'b10, 1'b1}};
        end
        default: begin
          base = 23'h7FFFFE;
          stim = '{8'h01, 8'h02, 8'h03, 8'h04};
          exp = '{'{22'h3FFFFF, 16'h0201, 2'b00, 1'b1}, '{22'h000000, 16'h0403, 2'b00, 1'b1}};
        end
      endcase
      drive_stream(base, -1, 1'b0);
      finish_stream(d0);
      tests++;
      if (writes.size() != exp.size()) begin
        fails++;
        $display("FAIL packing%0d_count got %0d writes required %0d", c, writes.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < writes.size(); i++) begin
        tests++;
        if (writes[i] !== exp[i]) begin
          fails++;
          $display("FAIL packing%0d_write%0d got a=%h d=%h wm=%b required a=%h d=%h wm=%b", c, i,
                   writes[i].addr, writes[i].data, writes[i].wm, exp[i].addr, exp[i].data, exp[i].wm);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int d0;
    logic [AB:0] base;
    prep();
    ack_delay = 20;
    base = 23'h000000;
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
    build_model(base);
    drive_stream(base, -1, 1'b0);
    finish_stream(d0);
    tests++;
    if (acc_before_ack != 2 * FD) begin
      fails++;
      $display("FAIL backpressure_accepted got %0d bytes before first ack required %0d", acc_before_ack, 2 * FD);
    end
    tests++;
    if (req_viol != 0) begin
      fails++;
      $display("FAIL backpressure_req_pulse got %0d held/overlapping reqs required 0", req_viol);
    end
    tests++;
    if (writes.size() != exp.size()) begin
      fails++;
      $display("FAIL backpressure_count got %0d writes required %0d", writes.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < writes.size(); i++) begin
      tests++;
      if (writes[i] !== exp[i]) begin
        fails++;
        $display("FAIL backpressure_write%0d got a=%h d=%h wm=%b required a=%h d=%h wm=%b", i,
                 writes[i].addr, writes[i].data, writes[i].wm, exp[i].addr, exp[i].data, exp[i].wm);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int d0;
    logic [AB:0] base;
    prep();
    ack_delay = 15;
    stim = '{8'h12, 8'h34};
    drive_stream(23'h000000, -1, 1'b0);
    guard = 0;
    while (writes.size() == 0 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    tests++;
    if (writes.size() != 1 || bus.req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got writes=%0d req=%b busy=%b required writes=1 req=0 busy=0", writes.size(), bus.req, busy);
    end
    prep();
    ack_delay = 2;
    base = 23'($urandom);
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    build_model(base);
    drive_stream(base, -1, 1'b0);
    finish_stream(d0);
    tests++;
    if (writes.size() != exp.size()) begin
      fails++;
      $display("FAIL reset_restart_count got %0d writes required %0d", writes.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < writes.size(); i++) begin
      tests++;
      if (writes[i] !== exp[i]) begin
        fails++;
        $display("FAIL reset_restart_write%0d got a=%h d=%h wm=%b required a=%h d=%h wm=%b", i,
                 writes[i].addr, writes[i].data, writes[i].wm, exp[i].addr, exp[i].data, exp[i].wm);
      end
    end
  endtask

  task automatic test_start_flush();
    int d0;
    logic [AB:0] base;
    prep();
    ack_delay = 2;
    base = 23'($urandom);
    stim.delete();
    for (int i = 0; i < 7; i++) stim.push_back(8'($urandom));
    build_model(base);
    drive_stream(base, 2, 1'b1);
    finish_stream(d0);
    tests++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_flush_done got pulses=%0d busy=%b required pulses=1 busy=0", done_cnt - d0, busy);
    end
    tests++;
    if (writes.size() != exp.size()) begin
      fails++;
      $display("FAIL start_flush_count got %0d writes required %0d", writes.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < writes.size(); i++) begin
      tests++;
      if (writes[i] !== exp[i]) begin
        fails++;
        $display("FAIL start_flush_write%0d got a=%h d=%h wm=%b required a=%h d=%h wm=%b", i,
                 writes[i].addr, writes[i].data, writes[i].wm, exp[i].addr, exp[i].data, exp[i].wm);
      end
    end
  endtask

  task automatic test_random();
    int d0;
    int n;
    logic [AB:0] base;
    for (int r = 0; r < 10; r++) begin
      prep();
      ack_delay = $urandom_range(1, 6);
      base = 23'($urandom);
      n = $urandom_range(1, 24);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      build_model(base);
      drive_stream(base, -1, 1'b0);
      finish_stream(d0);
      tests++;
      if (writes.size() != exp.size() || req_viol != 0) begin
        fails++;
        $display("FAIL random%0d_count got %0d writes viol=%0d required %0d writes viol=0", r, writes.size(), req_viol, exp.size());
      end
      for (int i = 0; i < exp.size() && i < writes.size(); i++) begin
        tests++;
        if (writes[i] !== exp[i]) begin
          fails++;
          $display("FAIL random%0d_write%0d got a=%h d=%h wm=%b required a=%h d=%h wm=%b", r, i,
                   writes[i].addr, writes[i].data, writes[i].wm, exp[i].addr, exp[i].data, exp[i].wm);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_basic();
    test_packing();
    test_backpressure();
    test_reset_mid();
    test_start_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
